std_div_pipe: RTL and testbench



---
 rtl/std_div_pipe_if.sv | 31 +++
 rtl/std_div_pipe.sv | 94 +++++++++
 tb/tb_std_div_pipe.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/std_div_pipe_if.sv
// std_div_pipe_if: go/done handshake plus operand and result buses for the iterative divider.
// Latency: none, this is wiring only.
// Backpressure: none; the client holds go until it observes the one-cycle done pulse.
interface std_div_pipe_if #(
  parameter int WIDTH = 32
);
  logic             go;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             done;

  modport master (
    output go,
    output left,
    output right,
    input  out_quotient,
    input  out_remainder,
    input  done
  );

  modport slave (
    input  go,
    input  left,
    input  right,
    output out_quotient,
    output out_remainder,
    output done
  );
endinterface

// File: rtl/std_div_pipe.sv
// std_div_pipe: iterative restoring unsigned divider giving quotient and remainder of WIDTH bits.
// Latency: WIDTH cycles from the go capture edge to the one-cycle done pulse; one op per WIDTH+2 cycles.
// Backpressure: none; go is sampled only in IDLE and is not queued, results hold until the next done.
module std_div_pipe #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  std_div_pipe_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // The dividend register doubles as the quotient register: dividend bits leave at the
  // top while quotient bits enter at the bottom, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   r_trial;
  logic [WIDTH-1:0] r_diff;
  logic             borrow;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step. The trial remainder is WIDTH+1 bits; its top bit set means it
  // already exceeds any WIDTH-bit divisor, so only the low WIDTH bits need subtracting.
  // With a zero divisor the subtract never borrows, giving all-ones quotient and
  // the dividend as remainder without a dedicated path.
  always_comb begin
    r_trial          = {rem_q, dvd_q[WIDTH-1]};
    {borrow, r_diff} = {1'b0, r_trial[WIDTH-1:0]} - {1'b0, dvs_q};
    take             = r_trial[WIDTH] | ~borrow;
    rem_next         = take ? r_diff : r_trial[WIDTH-1:0];
    quo_next         = (dvd_q << 1) | WIDTH'(take);
  end

  // Control FSM, operand capture and registered results; reset discards any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      dvd_q             <= '0;
      dvs_q             <= '0;
      rem_q             <= '0;
      cnt_q             <= '0;
      bus.out_quotient  <= '0;
      bus.out_remainder <= '0;
      bus.done          <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            dvd_q <= bus.left;
            dvs_q <= bus.right;
            rem_q <= '0;
            cnt_q <= CNT_LOAD;
            state <= BUSY;
          end
        end
        BUSY: begin
          dvd_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            bus.out_quotient  <= quo_next;
            bus.out_remainder <= rem_next;
            bus.done          <= 1'b1;
            state             <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_div_pipe.sv
`timescale 1ns/1ps
module tb_std_div_pipe;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  std_div_pipe_if #(.WIDTH(32)) b32 ();
  std_div_pipe_if #(.WIDTH(8))  b8  ();
  std_div_pipe_if #(.WIDTH(1))  b1  ();
  std_div_pipe_if #(.WIDTH(16)) b16 ();

  std_div_pipe #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
  std_div_pipe #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));
  std_div_pipe #(.WIDTH(1))  u1  (.clk(clk), .reset(reset), .bus(b1));
  std_div_pipe #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(b16));

  // Reference: plain arithmetic, divide by zero yields all ones and the dividend.
  function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a & mask;
    b = b & mask;
    if (b == 64'd0) begin
      q = mask;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic op32(input logic [31:0] a, input logic [31:0] b, output int lat,
                      output logic [31:0] q, output logic [31:0] r, output bit one);
    @(negedge clk);
    b32.left = a; b32.right = b; b32.go = 1'b1;
    @(negedge clk);
    b32.go = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (b32.done === 1'b1) begin lat = k; break; end
    end
    q = b32.out_quotient;
    r = b32.out_remainder;
    @(negedge clk);
    one = (b32.done === 1'b0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat,
                     output logic [7:0] q, output logic [7:0] r);
    @(negedge clk);
    b8.left = a; b8.right = b; b8.go = 1'b1;
    @(negedge clk);
    b8.go = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (b8.done === 1'b1) begin lat = k; break; end
      b8.left  = 8'($urandom);
      b8.right = 8'($urandom);
      b8.go    = (k <= 6) ? 1'($urandom) : 1'b0;
    end
    q = b8.out_quotient;
    r = b8.out_remainder;
    b8.go = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b, output int lat,
                     output logic q, output logic r, output bit one);
    @(negedge clk);
    b1.left = a; b1.right = b; b1.go = 1'b1;
    @(negedge clk);
    b1.go = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (b1.done === 1'b1) begin lat = k; break; end
    end
    q = b1.out_quotient;
    r = b1.out_remainder;
    @(negedge clk);
    one = (b1.done === 1'b0);
  endtask

  task automatic test_reset();
    b32.go = 1'b0; b32.left = '0; b32.right = '0;
    b8.go  = 1'b0; b8.left  = '0; b8.right  = '0;
    b1.go  = 1'b0; b1.left  = '0; b1.right  = '0;
    b16.go = 1'b0; b16.left = '0; b16.right = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (b32.done !== 1'b0) $display("FAIL reset done32: got %0b expected 0", b32.done); else n_pass++;
    n_checks++; if (b32.out_quotient !== 32'd0) $display("FAIL reset q32: got %0h expected 0", b32.out_quotient); else n_pass++;
    n_checks++; if (b32.out_remainder !== 32'd0) $display("FAIL reset r32: got %0h expected 0", b32.out_remainder); else n_pass++;
    n_checks++; if (b16.done !== 1'b0 || b8.done !== 1'b0 || b1.done !== 1'b0)
      $display("FAIL reset done_other: got %0b%0b%0b expected 000", b16.done, b8.done, b1.done); else n_pass++;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (b32.done !== 1'b0) $display("FAIL idle done32: got %0b expected 0", b32.done); else n_pass++;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] q, r; bit one; logic [63:0] eq, er; logic [31:0] a, b;
    op32(32'd100, 32'd7, lat, q, r, one);
    n_checks++; if (lat !== 32) $display("FAIL basic latency: got %0d expected 32", lat); else n_pass++;
    n_checks++; if (q !== 32'd14) $display("FAIL basic quotient: got %0d expected 14", q); else n_pass++;
    n_checks++; if (r !== 32'd2) $display("FAIL basic remainder: got %0d expected 2", r); else n_pass++;
    n_checks++; if (one !== 1'b1) $display("FAIL basic done_width: done still high the cycle after"); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i == 1) ? 32'($urandom_range(1, 15)) : ($urandom >> $urandom_range(0, 28));
      ref_div(32, {32'd0, a}, {32'd0, b}, eq, er);
      op32(a, b, lat, q, r, one);
      n_checks++; if (lat !== 32) $display("FAIL rand32 latency: got %0d expected 32", lat); else n_pass++;
      n_checks++; if (q !== eq[31:0]) $display("FAIL rand32 quotient %0h/%0h: got %0h expected %0h", a, b, q, eq[31:0]); else n_pass++;
      n_checks++; if (r !== er[31:0]) $display("FAIL rand32 remainder %0h/%0h: got %0h expected %0h", a, b, r, er[31:0]); else n_pass++;
    end
  endtask

  task automatic test_boundary();
    int lat; logic [31:0] q, r; bit one;
    op32(32'hFFFF_FFFF, 32'd1, lat, q, r, one);
    n_checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL max_by_one quotient: got %0h expected ffffffff", q); else n_pass++;
    n_checks++; if (r !== 32'd0) $display("FAIL max_by_one remainder: got %0h expected 0", r); else n_pass++;
    op32(32'd5, 32'd0, lat, q, r, one);
    n_checks++; if (lat !== 32) $display("FAIL div0 latency: got %0d expected 32", lat); else n_pass++;
    n_checks++; if (q !== 32'hFFFF_FFFF) $display("FAIL div0 quotient: got %0h expected ffffffff", q); else n_pass++;
    n_checks++; if (r !== 32'd5) $display("FAIL div0 remainder: got %0h expected 5", r); else n_pass++;
  endtask

  task automatic test_operand_hold();
    int lat; logic [7:0] q, r, a, b; logic [63:0] eq, er;
    op8(8'd200, 8'd13, lat, q, r);
    n_checks++; if (lat !== 8) $display("FAIL hold8 latency: got %0d expected 8", lat); else n_pass++;
    n_checks++; if (q !== 8'd15) $display("FAIL hold8 quotient: got %0d expected 15", q); else n_pass++;
    n_checks++; if (r !== 8'd5) $display("FAIL hold8 remainder: got %0d expected 5", r); else n_pass++;
    repeat (4) @(negedge clk);
    op8(8'd3, 8'd9, lat, q, r);
    n_checks++; if (q !== 8'd0) $display("FAIL small8 quotient: got %0d expected 0", q); else n_pass++;
    n_checks++; if (r !== 8'd3) $display("FAIL small8 remainder: got %0d expected 3", r); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      a = 8'($urandom);
      b = (i == 3) ? 8'd0 : 8'($urandom_range(0, 40));
      ref_div(8, {56'd0, a}, {56'd0, b}, eq, er);
      op8(a, b, lat, q, r);
      n_checks++; if (q !== eq[7:0]) $display("FAIL rand8 quotient %0d/%0d: got %0d expected %0d", a, b, q, eq[7:0]); else n_pass++;
      n_checks++; if (r !== er[7:0]) $display("FAIL rand8 remainder %0d/%0d: got %0d expected %0d", a, b, r, er[7:0]); else n_pass++;
    end
  endtask

  task automatic test_width1();
    int lat; logic q, r; bit one; logic [63:0] eq, er; logic a, b;
    for (int i = 0; i < 4; i++) begin
      a = (i >= 2);
      b = (i == 0 || i == 2);
      ref_div(1, {63'd0, a}, {63'd0, b}, eq, er);
      op1(a, b, lat, q, r, one);
      n_checks++; if (lat !== 1) $display("FAIL w1 latency %0b/%0b: got %0d expected 1", a, b, lat); else n_pass++;
      n_checks++; if (q !== eq[0]) $display("FAIL w1 quotient %0b/%0b: got %0b expected %0b", a, b, q, eq[0]); else n_pass++;
      n_checks++; if (r !== er[0]) $display("FAIL w1 remainder %0b/%0b: got %0b expected %0b", a, b, r, er[0]); else n_pass++;
      n_checks++; if (one !== 1'b1) $display("FAIL w1 done_width %0b/%0b: done high two cycles", a, b); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] la [3];
    logic [15:0] ra [3];
    logic [15:0] gq [3];
    logic [15:0] gr [3];
    int t [3];
    int n, unstable, doubles;
    bit prev_done;
    logic [63:0] eq, er;
    la[0] = 16'd1000;  ra[0] = 16'd10;
    la[1] = 16'd65535; ra[1] = 16'd256;
    la[2] = 16'd7;     ra[2] = 16'd7;
    n = 0; unstable = 0; doubles = 0; prev_done = 1'b0;
    for (int i = 0; i < 3; i++) begin t[i] = 0; gq[i] = '0; gr[i] = '0; end
    @(negedge clk);
    b16.left = la[0]; b16.right = ra[0]; b16.go = 1'b1;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(negedge clk);
      if (b16.done === 1'b1) begin
        if (prev_done) doubles++;
        t[n]  = cyc;
        gq[n] = b16.out_quotient;
        gr[n] = b16.out_remainder;
        n++;
        if (n < 3) begin b16.left = la[n]; b16.right = ra[n]; end
        else b16.go = 1'b0;
      end else if (n > 0 && (b16.out_quotient !== gq[n-1] || b16.out_remainder !== gr[n-1])) begin
        unstable++;
      end
      prev_done = (b16.done === 1'b1);
    end
    b16.go = 1'b0;
    n_checks++; if (n !== 3) $display("FAIL b2b completions: got %0d expected 3", n); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      ref_div(16, {48'd0, la[i]}, {48'd0, ra[i]}, eq, er);
      n_checks++; if (gq[i] !== eq[15:0]) $display("FAIL b2b quotient op%0d: got %0d expected %0d", i, gq[i], eq[15:0]); else n_pass++;
      n_checks++; if (gr[i] !== er[15:0]) $display("FAIL b2b remainder op%0d: got %0d expected %0d", i, gr[i], er[15:0]); else n_pass++;
    end
    n_checks++; if (t[1] - t[0] !== 18) $display("FAIL b2b spacing01: got %0d expected 18", t[1] - t[0]); else n_pass++;
    n_checks++; if (t[2] - t[1] !== 18) $display("FAIL b2b spacing12: got %0d expected 18", t[2] - t[1]); else n_pass++;
    n_checks++; if (unstable !== 0) $display("FAIL b2b hold: got %0d output changes between pulses expected 0", unstable); else n_pass++;
    n_checks++; if (doubles !== 0) $display("FAIL b2b double_done: got %0d expected 0", doubles); else n_pass++;
  endtask

  task automatic test_async_reset();
    int lat, stray; logic [31:0] q, r; bit one;
    @(negedge clk);
    b32.left = 32'd100; b32.right = 32'd7; b32.go = 1'b1;
    @(negedge clk);
    b32.go = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (b32.out_quotient !== 32'd0) $display("FAIL areset quotient: got %0h expected 0", b32.out_quotient); else n_pass++;
    n_checks++; if (b32.out_remainder !== 32'd0) $display("FAIL areset remainder: got %0h expected 0", b32.out_remainder); else n_pass++;
    n_checks++; if (b32.done !== 1'b0) $display("FAIL areset done: got %0b expected 0", b32.done); else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b32.done !== 1'b0 || b32.out_quotient !== 32'd0) stray++;
    end
    n_checks++; if (stray !== 0) $display("FAIL areset discard: got %0d cycles with done or result expected 0", stray); else n_pass++;
    op32(32'd100, 32'd7, lat, q, r, one);
    n_checks++; if (lat !== 32) $display("FAIL post_reset latency: got %0d expected 32", lat); else n_pass++;
    n_checks++; if (q !== 32'd14) $display("FAIL post_reset quotient: got %0d expected 14", q); else n_pass++;
    n_checks++; if (r !== 32'd2) $display("FAIL post_reset remainder: got %0d expected 2", r); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_operand_hold();
    test_width1();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
